// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller bundle between pipeline (master) and controller (slave)
interface pipeline_hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       MemReqM;
  logic       MemReadyM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control with boot purge and memory-wait watchdog
module pipeline_hazard_ctrl #(
  parameter int BOOT_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 15
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int BW = $clog2(BOOT_FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] boot_cnt;
  logic [WW-1:0] wait_cnt;
  logic          mem_timeout;

  logic lw_stall;
  logic mem_stall;

  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_stall = hz.MemReqM && !hz.MemReadyM;

  // The watchdog flag is sticky; only the asynchronous reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + BW'(1);
          if (boot_cnt == BOOT_LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_ONE;
            if (WAIT_ONE == WAIT_MAX) begin
              mem_timeout <= 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + WAIT_ONE;
              if (wait_cnt + WAIT_ONE == WAIT_MAX) begin
                mem_timeout <= 1'b1;
              end
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= BOOT;
          boot_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // A pending memory access freezes everything and hides Execute-stage hazards until it completes.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (state == BOOT) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = hz.PCSrcE;
      flush_e = lw_stall | hz.PCSrcE;
    end
  end

  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
      fwd_a = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
      fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
      fwd_b = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
      fwd_b = 2'b01;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemTimeout = mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .BOOT_FLUSH_CYCLES(2),
    .MEM_TIMEOUT      (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] CTL_BOOT  = 7'b1000110;
  localparam logic [6:0] CTL_IDLE  = 7'b0000000;
  localparam logic [6:0] CTL_MEM   = 7'b1111001;
  localparam logic [6:0] CTL_LWBR  = 7'b1100110;
  localparam logic [6:0] CTL_LW    = 7'b1100010;
  localparam logic [6:0] CTL_BR    = 7'b0000110;

  function automatic logic [6:0] ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
    hz.RdM = 5'd0; hz.RdW = 5'd0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic boot_sequence(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_boot_c1"}, 32'(ctl()), 32'(CTL_BOOT));
    tick();
    check({tag, "_boot_c2"}, 32'(ctl()), 32'(CTL_BOOT));
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #3;
    check("rst_ctl", 32'(ctl()), 32'(CTL_BOOT));
    check("rst_timeout", 32'(hz.MemTimeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_ctl", 32'(ctl()), 32'(CTL_BOOT));
    end

    boot_sequence("first");
    check("run_idle", 32'(ctl()), 32'(CTL_IDLE));
    check("run_fwd_idle", 32'({hz.ForwardAE, hz.ForwardBE}), 32'd0);

    // Forwarding priority: Memory over Writeback, x0 never forwarded.
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5; hz.Rs1E = 5'd5;
    hz.Rs2E = 5'd5;
    #1;
    check("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
    check("fwdB_mem", 32'(hz.ForwardBE), 32'd2);
    hz.RdM = 5'd0;
    #1;
    check("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
    check("fwdB_wb", 32'(hz.ForwardBE), 32'd1);
    hz.Rs2E = 5'd0; hz.RdW = 5'd0;
    #1;
    check("fwdB_none", 32'(hz.ForwardBE), 32'd0);
    check("fwdA_rdw0", 32'(hz.ForwardAE), 32'd0);
    hz.RdM = 5'd9; hz.Rs1E = 5'd9; hz.RegWriteM = 1'b0;
    #1;
    check("fwdA_nowrite", 32'(hz.ForwardAE), 32'd0);
    idle_inputs();

    // Load-use and branch combinations.
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
    #1;
    check("lw_branch", 32'(ctl()), 32'(CTL_LWBR));
    hz.RdE = 5'd0;
    #1;
    check("lw_rd0_branch", 32'(ctl()), 32'(CTL_BR));
    hz.RdE = 5'd7; hz.PCSrcE = 1'b0; hz.Rs2D = 5'd0; hz.Rs1D = 5'd7;
    #1;
    check("lw_rs1", 32'(ctl()), 32'(CTL_LW));
    hz.ResultSrcE = 2'b10;
    #1;
    check("nonload", 32'(ctl()), 32'(CTL_IDLE));

    // Memory wait masks load-use and branch; ready releases in the same cycle.
    hz.ResultSrcE = 2'b01; hz.PCSrcE = 1'b1; hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("memwait_ctl", 32'(ctl()), 32'(CTL_MEM));
      if (i < 3) tick();
    end
    hz.MemReadyM = 1'b1;
    #1;
    check("memready_rule2", 32'(ctl()), 32'(CTL_LWBR));
    tick();
    check("memready_timeout", 32'(hz.MemTimeout), 32'd0);
    idle_inputs();
    #1;
    check("after_wait_idle", 32'(ctl()), 32'(CTL_IDLE));

    // Watchdog: 15th consecutive stall cycle sets the sticky flag.
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("wd_edge%0d", i), 32'(hz.MemTimeout), (i >= 15) ? 32'd1 : 32'd0);
    end
    check("wd_still_stalled", 32'(ctl()), 32'(CTL_MEM));
    hz.MemReadyM = 1'b1;
    #1;
    check("wd_ready_ctl", 32'(ctl()), 32'(CTL_IDLE));
    tick();
    hz.MemReqM = 1'b0;
    tick();
    check("wd_sticky", 32'(hz.MemTimeout), 32'd1);

    // Reset during a wait at count 6 aborts asynchronously.
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_ctl", 32'(ctl()), 32'(CTL_MEM));
    rst = 1'b0;
    #1;
    check("async_rst_ctl", 32'(ctl()), 32'(CTL_BOOT));
    check("async_rst_timeout", 32'(hz.MemTimeout), 32'd0);
    tick();
    boot_sequence("second");
    check("reboot_run_memstall", 32'(ctl()), 32'(CTL_MEM));

    // Ready pulse between stalls restarts the wait count at 1.
    for (int i = 0; i < 9; i++) tick();
    check("b2b_pre_timeout", 32'(hz.MemTimeout), 32'd0);
    hz.MemReadyM = 1'b1;
    #1;
    check("b2b_ready_ctl", 32'(ctl()), 32'(CTL_IDLE));
    tick();
    hz.MemReadyM = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("b2b_edge%0d", i), 32'(hz.MemTimeout), (i >= 15) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage RV32I pipeline. It sits beside the Decode and Execute stages and drives stall, flush and forward-select signals to the pipeline registers and Execute operand muxes. It sequences a post-reset pipeline purge, resolves load-use and control hazards, and freezes the pipeline while the data memory is not ready, with a watchdog on memory waits.

## Interface
- BOOT_FLUSH_CYCLES, 2: cycles of forced fetch stall plus D/E flush after reset release; legal range ≥1.
- MEM_TIMEOUT, 15: consecutive memory-stall cycles before MemTimeout sets; legal range ≥1.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-low.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  sources and destination in Execute.
- ResultSrcE  in  2  value 2'b01 marks a load in Execute.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  5  destinations in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemReqM  in  1  load or store active in Memory.
- MemReadyM  in  1  data memory completes the Memory access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC and the D, E and M pipeline registers.
- FlushD, FlushE, FlushW  out  1  load a bubble into D, E or W.
- ForwardAE, ForwardBE  out  2  Execute operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- MemTimeout  out  1  sticky memory-watchdog flag.

## Operation
- The FSM has three states: BOOT, RUN and MEM_WAIT. It has a boot counter and a wait counter, each $clog2(max+1) bits wide.
- Forwarding is combinational in every state. Rules for A (B is identical using Rs2E):
  - 10 when RegWriteM, RdM≠0 and RdM==Rs1E.
  - Otherwise 01 when RegWriteW, RdW≠0 and RdW==Rs1E.
  - Otherwise 00.
- Internal terms:
  - lwStall = (ResultSrcE==2'b01) && RdE≠0 && (RdE==Rs1D || RdE==Rs2D).
  - memStall = MemReqM && !MemReadyM.
- BOOT:
  - StallF=1, FlushD=1, FlushE=1. All other stall/flush outputs are 0.
  - The boot counter increments each cycle. The FSM moves to RUN on the edge where the counter equals BOOT_FLUSH_CYCLES-1.
  - Memory inputs are ignored in BOOT.
- RUN and MEM_WAIT, priority order:
  1. If memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. lwStall and PCSrcE are suppressed. Execute is held, so both are re-evaluated after the wait.
  2. Else: StallF=StallD=lwStall, FlushD=PCSrcE, FlushE=lwStall|PCSrcE. StallE, StallM and FlushW are 0.
- Transitions:
  - RUN with memStall: go to MEM_WAIT and set wait counter to 1.
  - MEM_WAIT with memStall: wait counter increments, saturating at MEM_TIMEOUT.
  - MEM_WAIT with MemReadyM=1 or MemReqM=0: go to RUN and clear the wait counter. Outputs in that cycle follow rule 2.
- Watchdog: MemTimeout is set on the edge where the wait counter reaches MEM_TIMEOUT. It stays set until reset. Setting it does not release the stalls.

## Timing
- Reset asserted (rst=0), immediately and independent of clk:
  - State is BOOT; both counters are 0.
  - StallF=1, FlushD=1, FlushE=1.
  - StallD=StallE=StallM=FlushW=0, MemTimeout=0.
  - ForwardAE/BE remain a combinational function of their inputs.
- BOOT lasts exactly BOOT_FLUSH_CYCLES rising edges after rst deasserts. RUN outputs appear in the following cycle.
- All stall, flush and forward outputs are combinational from current state and inputs, with zero-cycle latency. Only state, counters and MemTimeout are registered.
- The first memory-stall cycle counts toward the watchdog. With continuous memStall, MemTimeout is high from the cycle after the MEM_TIMEOUT-th stall cycle.
- Back-to-back memory stalls, with a ready pulse between them, restart the wait counter at 1.
- Reset asserted mid-wait or mid-boot aborts immediately to the reset values and restarts the BOOT sequence.

## Test plan
- Boot: hold rst=0 for 3 cycles, then release with defaults. StallF, FlushD and FlushE are 1 during reset and for exactly 2 cycles after release. The FSM then reports RUN, with all outputs 0 when inputs are idle.
- Forwarding: set RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5. Expect ForwardAE=10. With RdM=0, expect ForwardAE=01. With Rs2E=0 and RdW=0, expect ForwardBE=00.
- Load-use plus branch: set ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=1. Expect StallF=StallD=1, FlushE=1, FlushD=1. With RdE=0, expect no stall, and only FlushD and FlushE from PCSrcE.
- Memory wait: hold MemReqM=1 and MemReadyM=0 for 4 cycles, with lwStall and PCSrcE also active. Expect all four stalls and FlushW high, and FlushD=FlushE=0. When MemReadyM=1, the stalls drop in that same cycle and rule-2 outputs appear.
- Watchdog: with MEM_TIMEOUT=15, hold memStall for 20 cycles. MemTimeout rises after the 15th stall cycle and stays set after ready returns. Only rst=0 clears it.
- Reset mid-wait: assert rst during MEM_WAIT with wait count 6. Outputs take the reset values asynchronously, and the full BOOT sequence repeats.
